// File: rtl/audio_pkg.sv
// Shared definitions for the codec read-side front end: default sample
// width, saturation bounds, capture FSM states and the stereo word layout.
package audio_pkg;

    localparam int SAMPLE_W = 24;

    localparam logic [SAMPLE_W-1:0] SAT_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACK    = 2'd1,
        SETTLE = 2'd2
    } cap_state_t;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_t;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous stereo FIFO, DEPTH words of W bits. Head is shown
// combinationally. Pushes while full are ignored unless a pop happens
// on the same edge; pops while empty are ignored. Overrun policy lives
// in the instantiating block.
module sample_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [LW-1:0] level_r;
    logic          do_push_s;
    logic          do_pop_s;

    assign empty     = (level_r == LW'(0));
    assign full      = (level_r == LW'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r];
    assign level     = level_r;

    // Storage array: write the tail slot on an accepted push.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            level_r  <= LW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

endmodule

// File: rtl/codec_sample_capture.sv
// Codec read-side front end: runs the read_ready/read handshake, captures
// stereo samples into sample_fifo, presents them via valid/ready and counts
// overruns. Optional feature macro: NOISE_INJECT_EN adds a saturating
// test-noise ramp to every stored sample.
module codec_sample_capture
    import audio_pkg::*;
#(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read_ready,
    input  logic [SAMPLE_W-1:0]    readdata_l,
    input  logic [SAMPLE_W-1:0]    readdata_r,
    output logic                   read,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [SAMPLE_W-1:0]    out_left,
    output logic [SAMPLE_W-1:0]    out_right,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    output logic [CNT_W-1:0]       drop_count
);

    cap_state_t              state_r;
    cap_state_t              state_s;
    logic                    read_r;
    logic                    overrun_r;
    logic [CNT_W-1:0]        drop_count_r;
    logic                    capture_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    drop_s;
    logic                    full_s;
    logic                    empty_s;
    logic [2*SAMPLE_W-1:0]   push_data_s;
    logic [2*SAMPLE_W-1:0]   head_s;
    logic [SAMPLE_W-1:0]     store_l_s;
    logic [SAMPLE_W-1:0]     store_r_s;

    // Only IDLE samples read_ready; SETTLE ignores a stale flag.
    assign capture_s = (state_r == IDLE) & read_ready;
    assign pop_s     = ~empty_s & out_ready;
    assign push_s    = capture_s & (~full_s | pop_s);
    assign drop_s    = capture_s & ~push_s;

`ifdef NOISE_INJECT_EN
    localparam logic [SAMPLE_W-1:0] SAT_HI = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic [SAMPLE_W-1:0] SAT_LO = {1'b1, {(SAMPLE_W-1){1'b0}}};

    logic [2:0] noise_c_r;

    // Sign-extended c * 2048 added with saturation to the sample range.
    function automatic logic [SAMPLE_W-1:0] add_noise(
        input logic [SAMPLE_W-1:0] x,
        input logic [2:0]          c
    );
        logic [SAMPLE_W-1:0] n;
        logic [SAMPLE_W:0]   sum;
        n   = {{(SAMPLE_W-14){c[2]}}, c, 11'd0};
        sum = {x[SAMPLE_W-1], x} + {n[SAMPLE_W-1], n};
        if (sum[SAMPLE_W] != sum[SAMPLE_W-1]) begin
            add_noise = sum[SAMPLE_W] ? SAT_LO : SAT_HI;
        end else begin
            add_noise = sum[SAMPLE_W-1:0];
        end
    endfunction

    // Noise ramp counter advances once per stored sample, wrapping 7 -> 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            noise_c_r <= 3'd0;
        end else if (push_s) begin
            noise_c_r <= noise_c_r + 3'd1;
        end
    end

    assign store_l_s = add_noise(readdata_l, noise_c_r);
    assign store_r_s = add_noise(readdata_r, noise_c_r);
`else
    assign store_l_s = readdata_l;
    assign store_r_s = readdata_r;
`endif

    assign push_data_s = {store_l_s, store_r_s};

    // Capture FSM next-state: IDLE -> ACK on a sample, then one SETTLE cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (read_ready) begin
                    state_s = ACK;
                end else begin
                    state_s = IDLE;
                end
            end
            ACK:     state_s = SETTLE;
            SETTLE:  state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Capture FSM state register and the registered codec pop strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            read_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            read_r  <= (state_s == ACK);
        end
    end

    // Sticky overrun flag and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_r    <= 1'b0;
            drop_count_r <= {CNT_W{1'b0}};
        end else if (drop_s) begin
            overrun_r <= 1'b1;
            if (drop_count_r != {CNT_W{1'b1}}) begin
                drop_count_r <= drop_count_r + CNT_W'(1);
            end
        end
    end

    sample_fifo #(
        .W     (2*SAMPLE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_s),
        .push_data (push_data_s),
        .pop       (pop_s),
        .pop_data  (head_s),
        .level     (level),
        .full      (full_s),
        .empty     (empty_s)
    );

    assign read       = read_r;
    assign overrun    = overrun_r;
    assign drop_count = drop_count_r;
    assign out_valid  = ~empty_s;
    // Head is masked while empty so stale slots never show.
    assign out_left   = empty_s ? {SAMPLE_W{1'b0}} : head_s[2*SAMPLE_W-1:SAMPLE_W];
    assign out_right  = empty_s ? {SAMPLE_W{1'b0}} : head_s[SAMPLE_W-1:0];

endmodule

// File: tb/tb_codec_sample_capture.sv
// Self-checking bench for codec_sample_capture. A queue-based reference
// model tracks accepted samples, drops and the read strobe; outputs are
// compared one time unit after every rising edge.
module tb_codec_sample_capture;
    import audio_pkg::*;

    localparam int SW    = SAMPLE_W;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           reset;
    logic           read_ready;
    logic [SW-1:0]  readdata_l;
    logic [SW-1:0]  readdata_r;
    logic           read;
    logic           out_valid;
    logic           out_ready;
    logic [SW-1:0]  out_left;
    logic [SW-1:0]  out_right;
    logic [LW-1:0]  level;
    logic           overrun;
    logic [CNT_W-1:0] drop_count;

    always #5 clk = ~clk;

    codec_sample_capture #(.SAMPLE_W(SW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .read_ready (read_ready),
        .readdata_l (readdata_l),
        .readdata_r (readdata_r),
        .read       (read),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_left   (out_left),
        .out_right  (out_right),
        .level      (level),
        .overrun    (overrun),
        .drop_count (drop_count)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    stereo_t q[$];
    int      cool;      // cycles before the codec may be sampled again
    bit      m_read;
    bit      m_over;
    int      m_drop;
    int      m_c;       // noise counter
    int      m_pushes;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [SW-1:0] noise(input logic [SW-1:0] x);
`ifdef NOISE_INJECT_EN
        int v;
        int n;
        logic [31:0] r;
        v = int'($signed(x));
        n = ((m_c >= 4) ? (m_c - 8) : m_c) * 2048;
        v = v + n;
        if (v > 8388607)  v = 8388607;
        if (v < -8388608) v = -8388608;
        r = v;
        return r[SW-1:0];
`else
        return x;
`endif
    endfunction

    task automatic model_reset();
        q.delete();
        cool   = 0;
        m_read = 1'b0;
        m_over = 1'b0;
        m_drop = 0;
        m_c    = 0;
    endtask

    task automatic model_edge();
        bit      pop;
        bit      cap;
        stereo_t w;
        pop = (q.size() != 0) && out_ready;
        cap = (cool == 0) && read_ready;
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) begin
                w.left  = noise(readdata_l);
                w.right = noise(readdata_r);
                q.push_back(w);
                m_c = (m_c + 1) % 8;
                m_pushes++;
            end else begin
                m_over = 1'b1;
                if (m_drop < (1 << CNT_W) - 1) m_drop++;
            end
        end
        m_read = cap;
        if (cap) cool = 2;
        else if (cool > 0) cool--;
    endtask

    task automatic compare();
        logic [SW-1:0] el;
        logic [SW-1:0] er;
        el = (q.size() != 0) ? q[0].left  : '0;
        er = (q.size() != 0) ? q[0].right : '0;
        check("read",       64'(read),       64'(m_read));
        check("out_valid",  64'(out_valid),  64'(q.size() != 0));
        check("level",      64'(level),      64'(q.size()));
        check("out_left",   64'(out_left),   64'(el));
        check("out_right",  64'(out_right),  64'(er));
        check("overrun",    64'(overrun),    64'(m_over));
        check("drop_count", 64'(drop_count), 64'(m_drop));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!reset) model_edge();
        #1;
        compare();
    endtask

    initial begin
        logic [SW-1:0] exp_l [8];
        logic [SW-1:0] exp_r [8];
        int            guard;

        reset      = 1'b1;
        read_ready = 1'b0;
        out_ready  = 1'b0;
        readdata_l = '0;
        readdata_r = '0;
        m_pushes   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare();
        reset = 1'b0;

        // Single capture.
        readdata_l = 24'h123456;
        readdata_r = 24'hFEDCBA;
        read_ready = 1'b1;
        cycle();
        check("t1_read",  64'(read),      64'd1);
        check("t1_level", 64'(level),     64'd1);
        check("t1_left",  64'(out_left),  64'h123456);
        check("t1_right", 64'(out_right), 64'hFEDCBA);
        read_ready = 1'b0;
        cycle();
        check("t1_read_pulse", 64'(read), 64'd0);
        out_ready = 1'b1;
        repeat (3) cycle();
        out_ready = 1'b0;

        // Sustained read_ready with a stalled consumer fills then overruns.
        read_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            readdata_l = SW'($urandom);
            readdata_r = SW'($urandom);
            cycle();
        end
        check("t2_level",   64'(level),      64'd4);
        check("t2_overrun", 64'(overrun),    64'd1);
        check("t2_drops",   64'(drop_count), 64'd1);

        // Capture and pop on the same edge while full: no drop.
        read_ready = 1'b0;
        repeat (2) cycle();
        readdata_l = 24'hABCDEF;
        readdata_r = 24'h0F0F0F;
        read_ready = 1'b1;
        out_ready  = 1'b1;
        cycle();
        check("t3_level", 64'(level),      64'd4);
        check("t3_drops", 64'(drop_count), 64'd1);
        read_ready = 1'b0;
        repeat (3) cycle();
        check("t3_tail_left", 64'(out_left), 64'(q.size() != 0 ? q[0].left : '0));
        repeat (3) cycle();
        check("t3_drained", 64'(out_valid), 64'd0);

        // Randomised traffic against the scoreboard.
        m_pushes = 0;
        guard    = 0;
        while (m_pushes < 100 && guard < 3000) begin
            read_ready = ($urandom_range(0, 3) != 0);
            out_ready  = $urandom_range(0, 1);
            readdata_l = SW'($urandom);
            readdata_r = SW'($urandom);
            cycle();
            guard++;
        end
        check("t4_budget", 64'(m_pushes >= 100), 64'd1);
        read_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (8) cycle();

        // Reset asserted while read is high.
        out_ready  = 1'b0;
        readdata_l = 24'h00AA55;
        readdata_r = 24'h55AA00;
        read_ready = 1'b1;
        cycle();
        check("t5_ack", 64'(read), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("t5_read_async", 64'(read),       64'd0);
        check("t5_level",      64'(level),      64'd0);
        check("t5_drops",      64'(drop_count), 64'd0);
        cycle();
        reset = 1'b0;
        cycle();
        check("t5_resume_read",  64'(read),     64'd1);
        check("t5_resume_level", 64'(level),    64'd1);
        check("t5_resume_left",  64'(out_left), 64'h00AA55);

        // Noise ramp starting from a fresh counter.
        read_ready = 1'b0;
        out_ready  = 1'b1;
        repeat (3) cycle();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        model_reset();
        reset = 1'b0;
`ifdef NOISE_INJECT_EN
        exp_l = '{24'h7FFFF0, 24'h7FFFFF, 24'h7FFFFF, 24'h7FFFFF,
                  24'h7FDFF0, 24'h7FE7F0, 24'h7FEFF0, 24'h7FF7F0};
        exp_r = '{24'h000000, 24'h000800, 24'h001000, 24'h001800,
                  24'hFFE000, 24'hFFE800, 24'hFFF000, 24'hFFF800};
`else
        for (int i = 0; i < 8; i++) begin
            exp_l[i] = 24'h7FFFF0;
            exp_r[i] = 24'h000000;
        end
`endif
        readdata_l = 24'h7FFFF0;
        readdata_r = 24'h000000;
        for (int i = 0; i < 8; i++) begin
            read_ready = 1'b1;
            cycle();
            check("t6_left",  64'(out_left),  64'(exp_l[i]));
            check("t6_right", 64'(out_right), 64'(exp_r[i]));
            read_ready = 1'b0;
            repeat (2) cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
